mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//   Data-memory side of the main-decoder control interface. Consumes memtoreg/memwrite/readtype
//   plus address and store data from the MEM stage. Runs each access on a 32-bit word bus with a
//   req/ack handshake: doublewords take two beats. Returns sign- or zero-extended 64-bit load data
//   and stalls the pipeline while busy.
// PARAMETERS
//   AW       32   byte-address width; memory bus word address is addr[AW-1:2]
//   TIMEOUT  255  max cycles mem_req may wait for mem_ack before the beat is aborted
// PORTS
//   clk        in   1      clock, all state on rising edge
//   reset      in   1      synchronous, active-low (0 = reset)
//   req_valid  in   1      MEM-stage request present
//   req_ready  out  1      unit idle, request accepted when req_valid&req_ready
//   memtoreg   in   1      load request
//   memwrite   in   2      00 none, 01 SW, 10 SB, 11 SD
//   readtype   in   3      000 LW(sext), 001 LWU, 010 LB(sext), 011 LBU, 100 LD; others illegal
//   addr       in   AW     byte address
//   wdata      in   64     store data (SW/SB use low bits)
//   rsp_valid  out  1      one-cycle completion pulse (loads and stores)
//   rdata      out  64     extended load data, valid with rsp_valid; 0 for stores/errors
//   err        out  1      with rsp_valid: misaligned, illegal, or timeout
//   stall      out  1      high whenever state != IDLE
//   mem_req    out  1      bus request, held until mem_ack
//   mem_we     out  1      bus write
//   mem_addr   out  AW-2   bus word address
//   mem_be     out  4      byte enables (lane i = bits 8i+7:8i, little-endian)
//   mem_wdata  out  32     bus write data
//   mem_ack    in   1      bus accepts beat this cycle (may be same cycle as mem_req rises)
//   mem_rdata  in   32     read data, valid when mem_ack & !mem_we
// BEHAVIOUR
//   - Reset: state IDLE; req_ready=1; rsp_valid, err, stall, mem_req, mem_we=0;
//     rdata, mem_addr, mem_be, mem_wdata = 0; timeout counter=0.
//   - FSM: IDLE -> BEAT0 -> (BEAT1 for LD/SD) -> RESP -> IDLE. Request fields are registered on
//     accept, so inputs may change afterwards.
//   - Accept: memwrite=00 and memtoreg=0 is a no-op. It is consumed with no response.
//   - Illegal requests go directly IDLE->RESP with err=1 and no bus activity: memwrite!=00 with
//     memtoreg=1, readtype 101-111, or misalignment. Alignment: LD/SD addr[2:0]=0;
//     LW/LWU/SW addr[1:0]=0; bytes are always aligned.
//   - BEAT0: mem_req=1, mem_addr=addr[AW-1:2].
//     - SW/SD: be=1111, wdata low word.
//     - SB: be=1<<addr[1:0], mem_wdata = {4{wdata[7:0]}}.
//     - Loads: be=1111, mem_we=0.
//   - BEAT1 (LD/SD only): mem_addr+1, SD sends wdata[63:32].
//   - Every bus output stays stable while mem_req=1 and !mem_ack. The next beat starts the cycle
//     after ack.
//   - Timeout: counter clears at each beat start and increments while waiting. Reaching TIMEOUT
//     drops mem_req, skips remaining beats and goes to RESP with err=1 and rdata=0.
//   - Load formatting:
//     - LW: sext(word).
//     - LWU: zext(word).
//     - LB: sext(byte lane addr[1:0]).
//     - LBU: zext of that byte.
//     - LD: {beat1, beat0}.
//   - RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready=1 only in IDLE.
//   - Min latency with ack in the same cycle as mem_req: word/byte op accepted at T, rsp_valid at
//     T+2, req_ready at T+3. LD/SD: rsp_valid at T+3.
//   - Reset low mid-access: next edge returns to IDLE, mem_req=0, no rsp_valid for the
//     aborted request.
// TESTING
//   - SW addr=0x100 wdata=0x11223344, ack immediate -> one beat: mem_addr=0x40, be=1111,
//     mem_wdata=0x11223344, rsp_valid at T+2, rdata=0.
//   - LB addr=0x103, mem_rdata=0x80FFFFFF -> rdata=0xFFFFFFFFFFFFFF80.
//     Repeat as LBU -> rdata=0x80.
//   - LD addr=0x208, beats return 0xDEADBEEF then 0x01234567 -> mem_addr 0x82 then 0x83,
//     rdata=0x01234567DEADBEEF.
//   - SD addr=0x204 (misaligned) -> no mem_req, rsp_valid with err=1.
//   - LW with mem_ack held low, TIMEOUT=4 -> mem_req high 4 cycles then drops, rsp_valid err=1,
//     rdata=0, stall high throughout.
//   - Assert reset=0 during SD BEAT1 wait -> next cycle IDLE, mem_req=0, no rsp_valid.
//     A following SB addr=0x2 wdata=0xAB drives be=0100, mem_wdata=0xABABABAB.

Source files
------------

// File: rtl/mem_access_unit.sv
// Data-memory access unit: turns MEM-stage load/store requests into one or two
// 32-bit req/ack bus beats and returns extended load data with a completion pulse.
module mem_access_unit #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          memtoreg,
    input  logic [1:0]    memwrite,
    input  logic [2:0]    readtype,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic          rsp_valid,
    output logic [63:0]   rdata,
    output logic          err,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata
);

    // The wait counter only has to reach TIMEOUT-1; the last waiting cycle aborts the beat.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        RESP
    } state_t;

    state_t        state;
    logic          op_store;
    logic          op_double;
    logic          op_byte;
    logic          op_signed;
    logic [1:0]    op_lane;
    logic [31:0]   wdata_hi;
    logic [31:0]   beat0_data;
    logic [CW-1:0] timer;

    logic          req_noop;
    logic          req_store;
    logic          req_double;
    logic          req_byte;
    logic          req_signed;
    logic          req_illegal;

    // Classify the incoming request: access size, signedness and whether it can go to the bus.
    always_comb begin
        req_noop    = !memtoreg && (memwrite == 2'b00);
        req_store   = !memtoreg && (memwrite != 2'b00);
        req_double  = 1'b0;
        req_byte    = 1'b0;
        req_signed  = 1'b0;
        req_illegal = 1'b0;
        if (memtoreg && (memwrite != 2'b00)) begin
            req_illegal = 1'b1;
        end else if (memtoreg) begin
            case (readtype)
                3'b000: req_signed = 1'b1;
                3'b001: req_signed = 1'b0;
                3'b010: begin
                    req_byte   = 1'b1;
                    req_signed = 1'b1;
                end
                3'b011: req_byte = 1'b1;
                3'b100: req_double = 1'b1;
                default: req_illegal = 1'b1;
            endcase
        end else begin
            req_byte   = (memwrite == 2'b10);
            req_double = (memwrite == 2'b11);
        end
        if (req_double && (addr[2:0] != 3'b000)) begin
            req_illegal = 1'b1;
        end else if (!req_byte && (addr[1:0] != 2'b00)) begin
            req_illegal = 1'b1;
        end
    end

    function automatic logic [63:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic        is_byte,
                                                input logic        is_signed);
        logic [31:0] shifted;
        logic [7:0]  lane_byte;
        shifted   = word >> {lane, 3'b000};
        lane_byte = shifted[7:0];
        if (is_byte) begin
            return is_signed ? {{56{lane_byte[7]}}, lane_byte} : {56'd0, lane_byte};
        end
        return is_signed ? {{32{word[31]}}, word} : {32'd0, word};
    endfunction

    // Access sequencer; every port it drives is a register, and bus outputs only
    // change on a beat start, on ack, or when a stuck beat is abandoned.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rdata      <= 64'd0;
            err        <= 1'b0;
            stall      <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= 4'd0;
            mem_wdata  <= 32'd0;
            op_store   <= 1'b0;
            op_double  <= 1'b0;
            op_byte    <= 1'b0;
            op_signed  <= 1'b0;
            op_lane    <= 2'd0;
            wdata_hi   <= 32'd0;
            beat0_data <= 32'd0;
            timer      <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    rdata <= 64'd0;
                    err   <= 1'b0;
                    if (req_valid && !req_noop) begin
                        op_store  <= req_store;
                        op_double <= req_double;
                        op_byte   <= req_byte;
                        op_signed <= req_signed;
                        op_lane   <= addr[1:0];
                        wdata_hi  <= wdata[63:32];
                        req_ready <= 1'b0;
                        stall     <= 1'b1;
                        if (req_illegal) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            err       <= 1'b1;
                        end else begin
                            state    <= BEAT0;
                            timer    <= '0;
                            mem_req  <= 1'b1;
                            mem_we   <= req_store;
                            mem_addr <= addr[AW-1:2];
                            mem_be   <= req_byte ? (4'b0001 << addr[1:0]) : 4'b1111;
                            if (!req_store) begin
                                mem_wdata <= 32'd0;
                            end else if (req_byte) begin
                                mem_wdata <= {4{wdata[7:0]}};
                            end else begin
                                mem_wdata <= wdata[31:0];
                            end
                        end
                    end
                end

                BEAT0, BEAT1: begin
                    if (mem_ack) begin
                        timer <= '0;
                        if ((state == BEAT0) && op_double) begin
                            state      <= BEAT1;
                            beat0_data <= mem_rdata;
                            mem_addr   <= mem_addr + (AW-2)'(1);
                            mem_wdata  <= op_store ? wdata_hi : 32'd0;
                        end else begin
                            state     <= RESP;
                            mem_req   <= 1'b0;
                            mem_we    <= 1'b0;
                            rsp_valid <= 1'b1;
                            err       <= 1'b0;
                            if (op_store) begin
                                rdata <= 64'd0;
                            end else if (op_double) begin
                                rdata <= {mem_rdata, beat0_data};
                            end else begin
                                rdata <= extend_load(mem_rdata, op_lane, op_byte, op_signed);
                            end
                        end
                    end else if (timer == TLIM) begin
                        // A stuck beat abandons the whole access, including any second beat.
                        state     <= RESP;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        rsp_valid <= 1'b1;
                        err       <= 1'b1;
                        rdata     <= 64'd0;
                    end else begin
                        timer <= timer + CW'(1);
                    end
                end

                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    stall     <= 1'b0;
                    rdata     <= 64'd0;
                    err       <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    stall     <= 1'b0;
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule
